// File: rtl/wb_unit_if.sv
// Writeback unit bus: ALU result, load issue/return, register-file write port and decode hazard query.
interface wb_unit_if #(parameter int XLEN = 32);
  logic            alu_valid;
  logic            alu_ready;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_result;
  logic            ld_issue_valid;
  logic            ld_issue_ready;
  logic [4:0]      ld_rd;
  logic [2:0]      ld_funct3;
  logic [1:0]      ld_addr_lo;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;
  logic            rf_we;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_wd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic            busy1;
  logic            busy2;
  logic            fwd1_valid;
  logic            fwd2_valid;
  logic [XLEN-1:0] fwd1_data;
  logic [XLEN-1:0] fwd2_data;

  modport slave (
    input  alu_valid, alu_rd, alu_result,
    input  ld_issue_valid, ld_rd, ld_funct3, ld_addr_lo,
    input  mem_rvalid, mem_rdata, rs1, rs2,
    output alu_ready, ld_issue_ready, rf_we, rf_rd, rf_wd,
    output busy1, busy2, fwd1_valid, fwd2_valid, fwd1_data, fwd2_data
  );

  modport master (
    output alu_valid, alu_rd, alu_result,
    output ld_issue_valid, ld_rd, ld_funct3, ld_addr_lo,
    output mem_rvalid, mem_rdata, rs1, rs2,
    input  alu_ready, ld_issue_ready, rf_we, rf_rd, rf_wd,
    input  busy1, busy2, fwd1_valid, fwd2_valid, fwd1_data, fwd2_data
  );
endinterface

// File: rtl/wb_unit.sv
// Writeback unit: merges ALU results with one outstanding load into the register-file write port.
// Optional forwarding from the registered write is enabled by defining WB_BYPASS_EN.
module wb_unit #(
  parameter int XLEN = 32
) (
  input logic      clk,
  input logic      rst,
  wb_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t          state;
  logic            alu_ready_q;
  logic            ld_ready_q;
  logic [4:0]      cap_rd;
  logic [2:0]      cap_f3;
  logic [1:0]      cap_lo;
  logic [XLEN-1:0] hold_wd;
  logic            we_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] wd_q;

  logic [7:0]      byte_lane;
  logic [15:0]     half_lane;
  logic [XLEN-1:0] ld_ext;
  logic            alu_acc;

  assign alu_acc = bus.alu_valid && alu_ready_q;

  always_comb begin
    byte_lane = bus.mem_rdata[7:0];
    case (cap_lo)
      2'd1:    byte_lane = bus.mem_rdata[15:8];
      2'd2:    byte_lane = bus.mem_rdata[23:16];
      2'd3:    byte_lane = bus.mem_rdata[31:24];
      default: byte_lane = bus.mem_rdata[7:0];
    endcase
    half_lane = cap_lo[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (cap_f3)
      3'b000:  ld_ext = {{24{byte_lane[7]}}, byte_lane};
      3'b001:  ld_ext = {{16{half_lane[15]}}, half_lane};
      3'b100:  ld_ext = {24'd0, byte_lane};
      3'b101:  ld_ext = {16'd0, half_lane};
      default: ld_ext = bus.mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      alu_ready_q <= 1'b1;
      ld_ready_q  <= 1'b1;
      cap_rd      <= '0;
      cap_f3      <= '0;
      cap_lo      <= '0;
      hold_wd     <= '0;
      we_q        <= 1'b0;
      rd_q        <= '0;
      wd_q        <= '0;
    end else begin
      we_q <= 1'b0;
      if (alu_acc) begin
        we_q <= (bus.alu_rd != '0);
        rd_q <= bus.alu_rd;
        wd_q <= bus.alu_result;
      end
      case (state)
        IDLE: begin
          if (bus.ld_issue_valid) begin
            state      <= WAIT;
            ld_ready_q <= 1'b0;
            cap_rd     <= bus.ld_rd;
            cap_f3     <= bus.ld_funct3;
            cap_lo     <= bus.ld_addr_lo;
          end
        end
        WAIT: begin
          if (bus.mem_rvalid) begin
            // ALU owns the port this edge; the load result waits one cycle in hold_wd
            if (bus.alu_valid) begin
              state       <= HOLD;
              alu_ready_q <= 1'b0;
              hold_wd     <= ld_ext;
            end else begin
              state      <= IDLE;
              ld_ready_q <= 1'b1;
              we_q       <= (cap_rd != '0);
              rd_q       <= cap_rd;
              wd_q       <= ld_ext;
            end
          end
        end
        HOLD: begin
          state       <= IDLE;
          alu_ready_q <= 1'b1;
          ld_ready_q  <= 1'b1;
          we_q        <= (cap_rd != '0);
          rd_q        <= cap_rd;
          wd_q        <= hold_wd;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic pend1, pend2, wr1, wr2;

  assign pend1 = (state != IDLE) && (bus.rs1 != '0) && (cap_rd == bus.rs1);
  assign pend2 = (state != IDLE) && (bus.rs2 != '0) && (cap_rd == bus.rs2);
  assign wr1   = we_q && (bus.rs1 != '0) && (rd_q == bus.rs1);
  assign wr2   = we_q && (bus.rs2 != '0) && (rd_q == bus.rs2);

  assign bus.alu_ready      = alu_ready_q;
  assign bus.ld_issue_ready = ld_ready_q;
  assign bus.rf_we          = we_q;
  assign bus.rf_rd          = rd_q;
  assign bus.rf_wd          = wd_q;

`ifdef WB_BYPASS_EN
  assign bus.busy1      = pend1;
  assign bus.busy2      = pend2;
  assign bus.fwd1_valid = wr1;
  assign bus.fwd2_valid = wr2;
  assign bus.fwd1_data  = wd_q;
  assign bus.fwd2_data  = wd_q;
`else
  assign bus.busy1      = pend1 || wr1;
  assign bus.busy2      = pend2 || wr2;
  assign bus.fwd1_valid = 1'b0;
  assign bus.fwd2_valid = 1'b0;
  assign bus.fwd1_data  = '0;
  assign bus.fwd2_data  = '0;
`endif

endmodule

// File: tb/tb_wb_unit.sv
// Self-checking bench for wb_unit: directed known-answer steps plus randomized traffic against a transaction model.
module tb_wb_unit;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_unit_if #(.XLEN(32)) bus();
  wb_unit #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  // transaction-level model: one outstanding load, one parked load result, the current registered write
  bit          m_pend, m_held;
  logic [4:0]  m_rd;
  logic [2:0]  m_f3;
  logic [1:0]  m_lo;
  logic [31:0] m_hold_val;
  bit          e_we;
  logic [4:0]  e_rd;
  logic [31:0] e_wd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] w);
    int unsigned bv, hv;
    bv = (w >> (int'(lo) * 8)) & 32'hFF;
    hv = (w >> (int'(lo[1]) * 16)) & 32'hFFFF;
    case (f3)
      3'b000:  return (bv >= 128) ? bv - 256 : bv;
      3'b001:  return (hv >= 32768) ? hv - 65536 : hv;
      3'b100:  return bv;
      3'b101:  return hv;
      default: return w;
    endcase
  endfunction

  function automatic logic exp_busy(input logic [4:0] rs);
    return (rs != 0) && ((((m_pend || m_held) && m_rd == rs)) || (!BYP && e_we && e_rd == rs));
  endfunction

  function automatic logic exp_fwd(input logic [4:0] rs);
    return BYP && e_we && (rs != 0) && (e_rd == rs);
  endfunction

  // Inputs are already driven; check pre-edge outputs, advance the model, clock, check the write port.
  task automatic cycle();
    bit          nwe;
    logic [4:0]  nrd;
    logic [31:0] nwd, v;
    #1;
    if (!rst) begin
      chkb("alu_ready", bus.alu_ready, !m_held);
      chkb("ld_issue_ready", bus.ld_issue_ready, !m_pend && !m_held);
      chkb("busy1", bus.busy1, exp_busy(bus.rs1));
      chkb("busy2", bus.busy2, exp_busy(bus.rs2));
      chkb("fwd1_valid", bus.fwd1_valid, exp_fwd(bus.rs1));
      chkb("fwd2_valid", bus.fwd2_valid, exp_fwd(bus.rs2));
      if (exp_fwd(bus.rs1)) chk("fwd1_data", bus.fwd1_data, e_wd);
      if (exp_fwd(bus.rs2)) chk("fwd2_data", bus.fwd2_data, e_wd);
      if (!BYP) chk("fwd_data_tied", bus.fwd1_data | bus.fwd2_data, 32'd0);
    end
    nwe = 1'b0; nrd = e_rd; nwd = e_wd;
    if (rst) begin
      m_pend = 1'b0; m_held = 1'b0; nrd = '0; nwd = '0;
    end else if (m_held) begin
      nwe = (m_rd != 0); nrd = m_rd; nwd = m_hold_val; m_held = 1'b0;
    end else begin
      if (bus.alu_valid) begin
        nwe = (bus.alu_rd != 0); nrd = bus.alu_rd; nwd = bus.alu_result;
      end
      if (m_pend && bus.mem_rvalid) begin
        v = extend(m_f3, m_lo, bus.mem_rdata);
        m_pend = 1'b0;
        if (bus.alu_valid) begin
          m_held = 1'b1; m_hold_val = v;
        end else begin
          nwe = (m_rd != 0); nrd = m_rd; nwd = v;
        end
      end else if (!m_pend && bus.ld_issue_valid) begin
        m_pend = 1'b1; m_rd = bus.ld_rd; m_f3 = bus.ld_funct3; m_lo = bus.ld_addr_lo;
      end
    end
    @(posedge clk);
    #1;
    e_we = nwe; e_rd = nrd; e_wd = nwd;
    chkb("rf_we", bus.rf_we, e_we);
    if (e_we || rst) begin
      chk("rf_rd", {27'd0, bus.rf_rd}, {27'd0, e_rd});
      chk("rf_wd", bus.rf_wd, e_wd);
    end
  endtask

  task automatic quiet();
    bus.alu_valid = 1'b0; bus.ld_issue_valid = 1'b0; bus.mem_rvalid = 1'b0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo);
    quiet();
    bus.ld_issue_valid = 1'b1; bus.ld_rd = rd; bus.ld_funct3 = f3; bus.ld_addr_lo = lo;
    cycle();
    bus.ld_issue_valid = 1'b0;
  endtask

  task automatic load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] d);
    issue(rd, f3, lo);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = d;
    cycle();
    bus.mem_rvalid = 1'b0;
  endtask

  initial begin
    m_pend = 0; m_held = 0; m_rd = '0; m_f3 = '0; m_lo = '0; m_hold_val = '0;
    e_we = 0; e_rd = '0; e_wd = '0;
    bus.alu_rd = '0; bus.alu_result = '0; bus.ld_rd = '0; bus.ld_funct3 = '0;
    bus.ld_addr_lo = '0; bus.mem_rdata = '0; bus.rs1 = '0; bus.rs2 = '0;
    quiet();

    rst = 1'b1; cycle(); cycle();
    rst = 1'b0;
    chkb("reset_we", bus.rf_we, 1'b0);
    chk("reset_rd", {27'd0, bus.rf_rd}, 32'd0);
    chk("reset_wd", bus.rf_wd, 32'd0);
    chkb("reset_busy1", bus.busy1, 1'b0);
    chkb("reset_ld_ready", bus.ld_issue_ready, 1'b1);
    cycle();

    // ALU write and rd=0 drop
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_result = 32'hDEADBEEF;
    cycle();
    chkb("alu_we", bus.rf_we, 1'b1);
    chk("alu_rd", {27'd0, bus.rf_rd}, 32'd5);
    chk("alu_wd", bus.rf_wd, 32'hDEADBEEF);
    bus.alu_rd = 5'd0;
    cycle();
    chkb("alu_x0_we", bus.rf_we, 1'b0);
    quiet();

    // load extension known answers
    load(5'd6, 3'b000, 2'd2, 32'h1280_3456); chk("lb", bus.rf_wd, 32'hFFFFFF80);
    load(5'd6, 3'b100, 2'd2, 32'h1280_3456); chk("lbu", bus.rf_wd, 32'h00000080);
    load(5'd6, 3'b001, 2'd2, 32'h1280_3456); chk("lh", bus.rf_wd, 32'h00001280);
    load(5'd6, 3'b010, 2'd2, 32'h1280_3456); chk("lw", bus.rf_wd, 32'h12803456);
    load(5'd6, 3'b101, 2'd0, 32'h1280_F456); chk("lhu", bus.rf_wd, 32'h0000F456);

    // collision: ALU x3 first, load x7 next; a held ALU op goes in after HOLD
    issue(5'd7, 3'b010, 2'd0);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hCAFE_0007;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_result = 32'h0000_0333;
    cycle();
    chk("coll_alu_rd", {27'd0, bus.rf_rd}, 32'd3);
    chkb("hold_alu_ready", bus.alu_ready, 1'b0);
    bus.mem_rvalid = 1'b0; bus.alu_rd = 5'd11; bus.alu_result = 32'h0000_0BBB;
    cycle();
    chk("coll_ld_rd", {27'd0, bus.rf_rd}, 32'd7);
    chk("coll_ld_wd", bus.rf_wd, 32'hCAFE_0007);
    cycle();
    chk("held_alu_rd", {27'd0, bus.rf_rd}, 32'd11);
    quiet();

    // load-use hazard on rs1
    bus.rs1 = 5'd9;
    issue(5'd9, 3'b010, 2'd0);
    chkb("haz_wait", bus.busy1, 1'b1);
    cycle();
    bus.mem_rvalid = 1'b1; bus.alu_valid = 1'b1; bus.alu_rd = 5'd2;
    cycle();
    chkb("haz_hold", bus.busy1, 1'b1);
    quiet();
    cycle();
    chkb("haz_write", bus.busy1, !BYP);
    cycle();
    chkb("haz_clear", bus.busy1, 1'b0);
    bus.rs1 = 5'd0;
    issue(5'd0, 3'b010, 2'd0);
    chkb("haz_x0", bus.busy1, 1'b0);
    bus.mem_rvalid = 1'b1; cycle(); quiet();

    // reset while a load is outstanding
    issue(5'd12, 3'b010, 2'd0);
    rst = 1'b1; cycle(); rst = 1'b0;
    chkb("rst_wait_ready", bus.ld_issue_ready, 1'b1);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1234_5678;
    cycle();
    chkb("rst_wait_no_we", bus.rf_we, 1'b0);
    quiet();

    // back-to-back dependency on rs2
    bus.rs2 = 5'd4; bus.alu_valid = 1'b1; bus.alu_rd = 5'd4; bus.alu_result = 32'h55;
    cycle();
    quiet();
    chkb("byp_busy2", bus.busy2, !BYP);
    chkb("byp_fwd2_valid", bus.fwd2_valid, BYP);
    if (BYP) chk("byp_fwd2_data", bus.fwd2_data, 32'h55);
    cycle();

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      if (!m_held) begin
        bus.alu_valid  = $urandom_range(0, 1) == 1;
        bus.alu_rd     = 5'($urandom_range(0, 7));
        bus.alu_result = $urandom;
      end
      bus.ld_issue_valid = $urandom_range(0, 2) == 0;
      bus.ld_rd          = 5'($urandom_range(0, 7));
      bus.ld_funct3      = 3'($urandom_range(0, 7));
      bus.ld_addr_lo     = 2'($urandom_range(0, 3));
      bus.mem_rvalid     = $urandom_range(0, 2) == 0;
      bus.mem_rdata      = $urandom;
      bus.rs1            = 5'($urandom_range(0, 7));
      bus.rs2            = 5'($urandom_range(0, 7));
      cycle();
    end
    rst = 1'b0;
    quiet();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
